// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and state encoding for the IF-stage fetch sequencer.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2,
        FETCH_OUT  = 2'd3
    } fetch_state_e;

    localparam int          Inst_Addr  = 32;
    localparam logic [31:0] Zero_Word  = 32'h0000_0000;
    localparam logic        Rst_Enable = 1'b1;
    localparam int          Inst_Step  = 4;

    // Redirect source select: flush outranks branch when both pulse together.
    function automatic logic [31:0] redirect_sel(
        input logic        flush,
        input logic [31:0] flush_pc,
        input logic [31:0] branch_target
    );
        return flush ? flush_pc : branch_target;
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, single-outstanding req/gnt/rvalid to imem.
// Latency: 3 cycles per instruction with zero-wait memory, +1 per gnt/rvalid wait cycle.
// Backpressure: stall_if holds the presented instruction in OUT; no new request until consumed.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = Inst_Addr,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_if,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [ADDR_W-1:0] imem_rdata,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_inst
);

    localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(Inst_Step);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(Zero_Word);

    fetch_state_e      state_q,    state_d;
    logic [ADDR_W-1:0] pc_q,       pc_d;
    logic [ADDR_W-1:0] issue_pc_q, issue_pc_d;
    logic [ADDR_W-1:0] if_pc_q,    if_pc_d;
    logic [ADDR_W-1:0] if_inst_q,  if_inst_d;
    logic              kill_q,     kill_d;
    logic              imem_req_q, imem_req_d;
    logic              if_valid_q, if_valid_d;

    logic              redirect_vld;
    logic [ADDR_W-1:0] redirect_pc;

    assign redirect_vld = flush | branch_flag;
    assign redirect_pc  = ADDR_W'(redirect_sel(flush, 32'(flush_pc), 32'(branch_target)));

    // Next-PC mux: flush > branch > +4 on grant > hold.
    always_comb begin
        pc_d = pc_q;
        if (redirect_vld) begin
            pc_d = redirect_pc;
        end else if (state_q == FETCH_REQ && imem_gnt) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_comb begin
        state_d    = state_q;
        issue_pc_d = issue_pc_q;
        kill_d     = kill_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;

        case (state_q)
            FETCH_IDLE: begin
                state_d = FETCH_REQ;
            end
            FETCH_REQ: begin
                if (imem_gnt) begin
                    state_d    = FETCH_WAIT;
                    issue_pc_d = pc_q;
                    // A redirect in the grant cycle makes the in-flight word stale.
                    kill_d     = redirect_vld;
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid) begin
                    kill_d = 1'b0;
                    if (kill_q || redirect_vld) begin
                        state_d = FETCH_REQ;
                    end else begin
                        state_d   = FETCH_OUT;
                        if_inst_d = imem_rdata;
                        if_pc_d   = issue_pc_q;
                    end
                end else if (redirect_vld) begin
                    kill_d = 1'b1;
                end
            end
            FETCH_OUT: begin
                // A redirect drops the held word even while IF/ID is stalled.
                if (redirect_vld || !stall_if) begin
                    state_d = FETCH_REQ;
                end
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase

        imem_req_d = (state_d == FETCH_REQ);
        if_valid_d = (state_d == FETCH_OUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == Rst_Enable) begin
            state_q    <= FETCH_IDLE;
            pc_q       <= RESET_PC;
            issue_pc_q <= ZERO_ADDR;
            if_pc_q    <= ZERO_ADDR;
            if_inst_q  <= ZERO_ADDR;
            kill_q     <= 1'b0;
            imem_req_q <= 1'b0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            issue_pc_q <= issue_pc_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            kill_q     <= kill_d;
            imem_req_q <= imem_req_d;
            if_valid_q <= if_valid_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_inst   = if_inst_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: hand-sequenced imem handshake with fixed expected addresses/words.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        stall_if;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        flush;
    logic [31:0] flush_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    int n_checks = 0;
    int n_errors = 0;

    fetch_ctrl #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .stall_if      (stall_if),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_inst       (if_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in REQ at addr, ends in the first OUT cycle.
    task automatic fetch_to_out(input logic [31:0] addr, input int gnt_wait, input int rv_wait);
        for (int i = 0; i < gnt_wait; i++) begin
            check("gnt_wait_req", imem_req, 1);
            check("gnt_wait_addr", imem_addr, addr);
            check("gnt_wait_valid", if_valid, 0);
            tick();
        end
        check("req", imem_req, 1);
        check("req_addr", imem_addr, addr);
        check("req_valid", if_valid, 0);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        check("wait_req", imem_req, 0);
        check("wait_valid", if_valid, 0);
        check("pc_inc", imem_addr, addr + 32'd4);
        for (int i = 0; i < rv_wait; i++) begin
            tick();
            check("rv_wait_req", imem_req, 0);
            check("rv_wait_valid", if_valid, 0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = word_of(addr);
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        check("out_valid", if_valid, 1);
        check("out_pc", if_pc, addr);
        check("out_inst", if_inst, word_of(addr));
        check("out_req", imem_req, 0);
    endtask

    // Full fetch; stall_if held for stall_cyc cycles of OUT. Ends in next REQ.
    task automatic do_fetch(input logic [31:0] addr, input int gnt_wait, input int rv_wait,
                            input int stall_cyc);
        fetch_to_out(addr, gnt_wait, rv_wait);
        for (int i = 0; i < stall_cyc; i++) begin
            stall_if = 1'b1;
            tick();
            check("stall_valid", if_valid, 1);
            check("stall_pc", if_pc, addr);
            check("stall_inst", if_inst, word_of(addr));
            check("stall_req", imem_req, 0);
        end
        stall_if = 1'b0;
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        stall_if      = 1'b0;
        branch_flag   = 1'b0;
        branch_target = 32'h0;
        flush         = 1'b0;
        flush_pc      = 32'h0;
        imem_gnt      = 1'b0;
        imem_rvalid   = 1'b0;
        imem_rdata    = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req", imem_req, 0);
        check("rst_valid", if_valid, 0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_inst", if_inst, 32'h0);

        rst = 1'b0;
        check("idle_req", imem_req, 0);
        tick();
        check("first_req", imem_req, 1);
        check("first_addr", imem_addr, 32'h0);

        // Zero-wait stream, stall at 4, gnt delay at 8, rvalid delay at 12.
        do_fetch(32'h0, 0, 0, 0);
        do_fetch(32'h4, 0, 0, 5);
        do_fetch(32'h8, 3, 0, 0);
        do_fetch(32'hC, 0, 2, 0);

        // Branch while WAIT at 0x10: returning word is discarded.
        check("br_req_addr", imem_addr, 32'h10);
        imem_gnt = 1'b1;
        tick();
        imem_gnt      = 1'b0;
        branch_flag   = 1'b1;
        branch_target = 32'h100;
        tick();
        branch_flag = 1'b0;
        check("br_wait_req", imem_req, 0);
        check("br_wait_addr", imem_addr, 32'h100);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        check("br_kill_valid", if_valid, 0);
        check("br_new_req", imem_req, 1);
        check("br_new_addr", imem_addr, 32'h100);
        do_fetch(32'h100, 0, 0, 0);
        do_fetch(32'h104, 0, 0, 0);

        // Flush and branch together in a granted REQ cycle: flush wins, word killed.
        check("fl_req_addr", imem_addr, 32'h108);
        imem_gnt      = 1'b1;
        flush         = 1'b1;
        flush_pc      = 32'h180;
        branch_flag   = 1'b1;
        branch_target = 32'h200;
        tick();
        imem_gnt    = 1'b0;
        flush       = 1'b0;
        branch_flag = 1'b0;
        check("fl_wait_req", imem_req, 0);
        check("fl_wait_addr", imem_addr, 32'h180);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0108;
        tick();
        imem_rvalid = 1'b0;
        check("fl_kill_valid", if_valid, 0);
        check("fl_new_req", imem_req, 1);
        check("fl_new_addr", imem_addr, 32'h180);
        do_fetch(32'h180, 0, 0, 0);

        // Branch in REQ without gnt to the top word, then wrap.
        branch_flag   = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        tick();
        branch_flag = 1'b0;
        check("wrap_req", imem_req, 1);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        fetch_to_out(32'hFFFF_FFFC, 0, 0);
        check("wrap_next_pc", imem_addr, 32'h0);

        // Flush from OUT under stall: held word dropped, new request next cycle.
        stall_if = 1'b1;
        flush    = 1'b1;
        flush_pc = 32'h40;
        tick();
        stall_if = 1'b0;
        flush    = 1'b0;
        check("out_fl_valid", if_valid, 0);
        check("out_fl_req", imem_req, 1);
        check("out_fl_addr", imem_addr, 32'h40);

        // Asynchronous reset in the middle of WAIT.
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        check("pre_rst_req", imem_req, 0);
        check("pre_rst_if_pc", if_pc, 32'hFFFF_FFFC);
        #2;
        rst = 1'b1;
        #1;
        check("arst_req", imem_req, 0);
        check("arst_valid", if_valid, 0);
        check("arst_addr", imem_addr, 32'h0);
        check("arst_if_pc", if_pc, 32'h0);
        check("arst_if_inst", if_inst, 32'h0);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0040;
        check("late_rv_idle_req", imem_req, 0);
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        check("late_rv_valid", if_valid, 0);
        check("late_rv_req", imem_req, 1);
        check("restart_addr", imem_addr, 32'h0);
        do_fetch(32'h0, 0, 0, 0);
        do_fetch(32'h4, 0, 0, 0);
        check("end_addr", imem_addr, 32'h8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
